// File: rtl/bp_io_host_responder.sv
// bp_io_host_responder: target end of the core's uncached I/O port for the host
// device window. Each accepted command gets exactly one response. The window holds
// getchar, putchar, finish and a free-running 64-bit cycle counter.
// Message layout, LSB first: data[63:0], msg_type[3:0], addr[paddr-1:0], size[2:0], payload.
// The widths normally derived from the processor config are exposed as parameters.
// Optional feature macro: BP_IO_HOST_GETCHAR_EN (getchar reads sample the host input
// and the getchar_yumi_o port is added).
module bp_io_host_responder #(
    parameter int paddr_width_p        = 40,
    parameter int payload_width_p      = 16,
    parameter int char_width_p         = 8,
    parameter int finish_width_p       = 8,
    parameter int cce_mem_msg_width_lp = payload_width_p + 3 + paddr_width_p + 4 + 64
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
    input  logic                            io_cmd_v_i,
    output logic                            io_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
    output logic                            io_resp_v_o,
    input  logic                            io_resp_yumi_i,
    output logic [char_width_p-1:0]         char_o,
    output logic                            char_v_o,
    input  logic                            char_ready_i,
    input  logic [char_width_p-1:0]         getchar_i,
    input  logic                            getchar_v_i,
`ifdef BP_IO_HOST_GETCHAR_EN
    output logic                            getchar_yumi_o,
`endif
    output logic                            finish_o,
    output logic [finish_width_p-1:0]       finish_code_o,
    output logic                            unmapped_o
);

    // state       | meaning
    // e_ready     | waiting for a command (ready held low for one cycle after reset)
    // e_char_wait | putchar presented to host, waiting for char_ready_i
    // e_resp      | response valid, waiting for io_resp_yumi_i
    typedef enum logic [1:0] {e_ready, e_char_wait, e_resp} state_e;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3
    } msg_type_e;

    localparam int type_lsb_lp = 64;
    localparam int addr_lsb_lp = 68;

    state_e                  state_r;
    logic                    ready_r;
    logic                    resp_v_r;
    logic [cce_mem_msg_width_lp-1:0] resp_r;
    logic                    char_v_r;
    logic [char_width_p-1:0] char_r;
    logic                    finish_r;
    logic [finish_width_p-1:0] finish_code_r;
    logic                    unmapped_r;
    logic [63:0]             cycle_r;

    logic [3:0]  cmd_type;
    logic [19:0] cmd_offset;
    logic [63:0] cmd_data;
    logic        is_rd, is_wr;
    logic        sel_getchar, sel_putchar, sel_finish, sel_cycle;
    logic        mapped, accept;
    logic [63:0] getchar_value;
    logic [63:0] rd_data;

    assign cmd_type    = io_cmd_i[type_lsb_lp+3:type_lsb_lp];
    assign cmd_offset  = io_cmd_i[addr_lsb_lp+19:addr_lsb_lp];
    assign cmd_data    = io_cmd_i[63:0];
    assign is_rd       = (cmd_type == e_cce_mem_uc_rd);
    assign is_wr       = (cmd_type == e_cce_mem_uc_wr);
    assign sel_getchar = (cmd_offset == 20'h00000);
    assign sel_putchar = (cmd_offset == 20'h01000);
    assign sel_finish  = (cmd_offset == 20'h02000);
    assign sel_cycle   = (cmd_offset == 20'h03000);
    assign mapped      = (is_rd | is_wr) & (sel_getchar | sel_putchar | sel_finish | sel_cycle);
    assign accept      = io_cmd_v_i & ready_r;

`ifdef BP_IO_HOST_GETCHAR_EN
    assign getchar_value  = getchar_v_i ? {{(64-char_width_p){1'b0}}, getchar_i} : '1;
    // Consume in the same cycle the character is sampled so the host never double-delivers.
    assign getchar_yumi_o = accept & is_rd & sel_getchar & getchar_v_i;
    logic unused_cmd;
    assign unused_cmd = ^cmd_data;
`else
    assign getchar_value = '1;
    logic unused_cmd;
    assign unused_cmd = ^{cmd_data, getchar_i, getchar_v_i};
`endif

    // Read mux: unmapped offsets, putchar reads and non-read types all return zero.
    always_comb begin
        rd_data = '0;
        if (is_rd) begin
            if (sel_getchar)     rd_data = getchar_value;
            else if (sel_finish) rd_data = {{(64-finish_width_p){1'b0}}, finish_code_r};
            else if (sel_cycle)  rd_data = cycle_r;
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cycle_r <= '0;
        else            cycle_r <= cycle_r + 64'd1;
    end

    // Command/response FSM with all handshake outputs registered.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= e_ready;
            ready_r       <= 1'b0;
            resp_v_r      <= 1'b0;
            resp_r        <= '0;
            char_v_r      <= 1'b0;
            char_r        <= '0;
            finish_r      <= 1'b0;
            finish_code_r <= '0;
            unmapped_r    <= 1'b0;
        end else begin
            case (state_r)
                e_ready: begin
                    ready_r <= 1'b1;
                    if (accept) begin
                        ready_r <= 1'b0;
                        resp_r  <= {io_cmd_i[cce_mem_msg_width_lp-1:64], rd_data};
                        if (!mapped) unmapped_r <= 1'b1;
                        if (is_wr && sel_finish) begin
                            finish_r      <= 1'b1;
                            finish_code_r <= cmd_data[finish_width_p-1:0];
                        end
                        if (is_wr && sel_putchar) begin
                            char_v_r <= 1'b1;
                            char_r   <= cmd_data[char_width_p-1:0];
                            state_r  <= e_char_wait;
                        end else begin
                            resp_v_r <= 1'b1;
                            state_r  <= e_resp;
                        end
                    end
                end
                e_char_wait: begin
                    if (char_ready_i) begin
                        char_v_r <= 1'b0;
                        resp_v_r <= 1'b1;
                        state_r  <= e_resp;
                    end
                end
                e_resp: begin
                    if (io_resp_yumi_i) begin
                        resp_v_r <= 1'b0;
                        ready_r  <= 1'b1;
                        state_r  <= e_ready;
                    end
                end
                default: begin
                    state_r <= e_ready;
                end
            endcase
        end
    end

    assign io_cmd_ready_o = ready_r;
    assign io_resp_o      = resp_r;
    assign io_resp_v_o    = resp_v_r;
    assign char_o         = char_r;
    assign char_v_o       = char_v_r;
    assign finish_o       = finish_r;
    assign finish_code_o  = finish_code_r;
    assign unmapped_o     = unmapped_r;

endmodule

// File: tb/tb_bp_io_host_responder.sv
// Directed bench for bp_io_host_responder: putchar wait, counter reads, finish,
// unmapped offsets, response hold, getchar and mid-operation reset.
module tb_bp_io_host_responder;

    localparam int paddr_lp = 40;
    localparam int payload_lp = 16;
    localparam int msg_w_lp = payload_lp + 3 + paddr_lp + 4 + 64;

    localparam logic [3:0] t_rd    = 4'd0;
    localparam logic [3:0] t_uc_rd = 4'd2;
    localparam logic [3:0] t_uc_wr = 4'd3;

    logic                clk_i = 1'b0;
    logic                reset_n_i = 1'b0;
    logic [msg_w_lp-1:0] io_cmd_i = '0;
    logic                io_cmd_v_i = 1'b0;
    logic                io_cmd_ready_o;
    logic [msg_w_lp-1:0] io_resp_o;
    logic                io_resp_v_o;
    logic                io_resp_yumi_i = 1'b0;
    logic [7:0]          char_o;
    logic                char_v_o;
    logic                char_ready_i = 1'b0;
    logic [7:0]          getchar_i = '0;
    logic                getchar_v_i = 1'b0;
`ifdef BP_IO_HOST_GETCHAR_EN
    logic                getchar_yumi_o;
`endif
    logic                finish_o;
    logic [7:0]          finish_code_o;
    logic                unmapped_o;

    int n_vec = 0;
    int n_err = 0;

    bp_io_host_responder #(
        .paddr_width_p(paddr_lp), .payload_width_p(payload_lp),
        .char_width_p(8), .finish_width_p(8)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
        .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
        .char_o(char_o), .char_v_o(char_v_o), .char_ready_i(char_ready_i),
        .getchar_i(getchar_i), .getchar_v_i(getchar_v_i),
`ifdef BP_IO_HOST_GETCHAR_EN
        .getchar_yumi_o(getchar_yumi_o),
`endif
        .finish_o(finish_o), .finish_code_o(finish_code_o), .unmapped_o(unmapped_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [msg_w_lp-1:0] obs, input logic [msg_w_lp-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [msg_w_lp-1:0] mk_msg(input logic [3:0] t, input logic [19:0] off,
                                                   input logic [63:0] d, input logic [15:0] p);
        logic [paddr_lp-1:0] a;
        a = {{(paddr_lp-32){1'b0}}, 12'h800, off};
        return {p, 3'b011, a, t, d};
    endfunction

    function automatic logic [msg_w_lp-1:0] hdr_only(input logic [msg_w_lp-1:0] m);
        return {m[msg_w_lp-1:64], 64'h0};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input string tag, input logic [msg_w_lp-1:0] m);
        io_cmd_i   = m;
        io_cmd_v_i = 1'b1;
        for (int i = 0; i < 20 && !io_cmd_ready_o; i++) @(negedge clk_i);
        chk({tag, "_ready"}, {{(msg_w_lp-1){1'b0}}, io_cmd_ready_o}, 1);
        @(negedge clk_i);
        io_cmd_v_i = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        for (int i = 0; i < 20 && !io_resp_v_o; i++) @(negedge clk_i);
        chk({tag, "_resp_v"}, {{(msg_w_lp-1){1'b0}}, io_resp_v_o}, 1);
    endtask

    task automatic take_resp();
        io_resp_yumi_i = 1'b1;
        @(negedge clk_i);
        io_resp_yumi_i = 1'b0;
    endtask

    logic [msg_w_lp-1:0] m, snap;
    logic [63:0] cap [3];
    int          cap_idx [3];
    int          ncap;

    initial begin
        // reset values
        #12;
        chk("rst_ready", io_cmd_ready_o, 0);
        chk("rst_resp_v", io_resp_v_o, 0);
        chk("rst_resp", io_resp_o, 0);
        chk("rst_char_v", char_v_o, 0);
        chk("rst_finish", finish_o, 0);
        chk("rst_unmapped", unmapped_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", io_cmd_ready_o, 1);

        // 1. putchar with host stalling three cycles
        m = mk_msg(t_uc_wr, 20'h01000, 64'h41, 16'h00AB);
        send("put", m);
        for (int i = 0; i < 3; i++) begin
            chk("put_char_v", char_v_o, 1);
            chk("put_char", char_o, 8'h41);
            chk("put_no_resp", io_resp_v_o, 0);
            @(negedge clk_i);
        end
        char_ready_i = 1'b1;
        @(negedge clk_i);
        char_ready_i = 1'b0;
        chk("put_resp_v", io_resp_v_o, 1);
        chk("put_char_off", char_v_o, 0);
        chk("put_resp", io_resp_o, hdr_only(m));
        chk("put_lce_id", io_resp_o[msg_w_lp-1 -: 16], 16'h00AB);
        take_resp();

        // 2. back-to-back counter reads with immediate yumi
        io_cmd_i = mk_msg(t_uc_rd, 20'h03000, 64'h0, 16'h0011);
        io_cmd_v_i = 1'b1;
        io_resp_yumi_i = 1'b1;
        ncap = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (io_resp_v_o && ncap < 3) begin
                cap[ncap] = io_resp_o[63:0];
                cap_idx[ncap] = i;
                ncap++;
            end
        end
        io_cmd_v_i = 1'b0;
        io_resp_yumi_i = 1'b0;
        chk("cyc_count", ncap, 3);
        chk("cyc_spacing", cap_idx[1] - cap_idx[0], 2);
        chk("cyc_delta2", cap[1] - cap[0], 64'd2);
        chk("cyc_delta4", cap[2] - cap[0], 64'd4);
        @(negedge clk_i);

        // 3. finish, latest write wins
        send("fin0", mk_msg(t_uc_wr, 20'h02000, 64'h00, 16'h0001));
        chk("fin0_flag", finish_o, 1);
        chk("fin0_code", finish_code_o, 8'h00);
        wait_resp("fin0");
        take_resp();
        send("fin5", mk_msg(t_uc_wr, 20'h02000, 64'h05, 16'h0002));
        chk("fin5_code", finish_code_o, 8'h05);
        wait_resp("fin5");
        take_resp();
        m = mk_msg(t_uc_rd, 20'h02000, 64'h0, 16'h0003);
        send("finrd", m);
        wait_resp("finrd");
        chk("finrd_data", io_resp_o, hdr_only(m) | 5);
        take_resp();

        // 4. unmapped offsets and types
        chk("unm_before", unmapped_o, 0);
        m = mk_msg(t_uc_rd, 20'h04000, 64'h0, 16'h0004);
        send("unm_rd", m);
        wait_resp("unm_rd");
        chk("unm_rd_resp", io_resp_o, hdr_only(m));
        chk("unm_flag", unmapped_o, 1);
        take_resp();
        send("unm_wr", mk_msg(t_uc_wr, 20'h04000, 64'h99, 16'h0005));
        chk("unm_wr_char", char_v_o, 0);
        chk("unm_wr_fin", finish_code_o, 8'h05);
        wait_resp("unm_wr");
        take_resp();
        m = mk_msg(t_rd, 20'h03000, 64'h0, 16'h0006);
        send("badtype", m);
        wait_resp("badtype");
        chk("badtype_resp", io_resp_o, hdr_only(m));
        take_resp();

        // 5. response held while not consumed
        send("hold", mk_msg(t_uc_rd, 20'h03000, 64'h0, 16'h0007));
        wait_resp("hold");
        snap = io_resp_o;
        io_cmd_i = mk_msg(t_uc_wr, 20'h02000, 64'h77, 16'h0008);
        io_cmd_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_ready", io_cmd_ready_o, 0);
            chk("hold_v", io_resp_v_o, 1);
            chk("hold_resp", io_resp_o, snap);
        end
        io_cmd_v_i = 1'b0;
        chk("hold_fin", finish_code_o, 8'h05);
        take_resp();

        // 6. getchar
        getchar_i = 8'h7A;
        getchar_v_i = 1'b1;
        m = mk_msg(t_uc_rd, 20'h00000, 64'h0, 16'h0009);
        send("getc", m);
        getchar_v_i = 1'b0;
        wait_resp("getc");
`ifdef BP_IO_HOST_GETCHAR_EN
        chk("getc_data", io_resp_o, hdr_only(m) | 64'h7A);
`else
        chk("getc_data", io_resp_o, hdr_only(m) | 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        take_resp();

        // reset during char wait
        send("rstp", mk_msg(t_uc_wr, 20'h01000, 64'h42, 16'h000A));
        chk("rstp_char_v", char_v_o, 1);
        reset_n_i = 1'b0;
        #1;
        chk("rstp_char_v0", char_v_o, 0);
        chk("rstp_char0", char_o, 0);
        chk("rstp_ready0", io_cmd_ready_o, 0);
        chk("rstp_resp0", io_resp_o, 0);
        chk("rstp_fin0", finish_o, 0);
        chk("rstp_code0", finish_code_o, 0);
        chk("rstp_unm0", unmapped_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        char_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rstp_no_resp", io_resp_v_o, 0);
            chk("rstp_no_char", char_v_o, 0);
        end
        char_ready_i = 1'b0;
        chk("rstp_ready", io_cmd_ready_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
